// File: rtl/channel_model_param_if.sv
// rtl/channel_model_param_if.sv - sample, configuration and status signals of the channel model
interface channel_model_param_if #(
  parameter int WIDTH = 18,
  parameter int DLY_W = 4,
  parameter int CNT_W = 16
);
  logic                    sam_clk_ena;
  logic                    sym_clk_ena;
  logic                    awgn_en;
  logic                    echo_en;
  logic [1:0]              gain_set;
  logic signed [WIDTH-1:0] echo_gain;
  logic [DLY_W-1:0]        echo_delay;
  logic signed [WIDTH-1:0] noise_in;
  logic signed [WIDTH-1:0] sig_in;
  logic                    sat_clr;
  logic signed [WIDTH-1:0] sig_out;
  logic                    sig_valid;
  logic [CNT_W-1:0]        sat_count;

  modport master (
    output sam_clk_ena, sym_clk_ena, awgn_en, echo_en, gain_set, echo_gain,
           echo_delay, noise_in, sig_in, sat_clr,
    input  sig_out, sig_valid, sat_count
  );

  modport slave (
    input  sam_clk_ena, sym_clk_ena, awgn_en, echo_en, gain_set, echo_gain,
           echo_delay, noise_in, sig_in, sat_clr,
    output sig_out, sig_valid, sat_count
  );
endinterface

// File: rtl/channel_model_param.sv
// rtl/channel_model_param.sv - baseband channel: gain, single echo tap, additive noise; CHAN_SAT_EN selects clamping
module channel_model_param #(
  parameter int WIDTH      = 18,
  parameter int GAIN_FRAC  = 9,
  parameter int ECHO_DEPTH = 16,
  parameter int DLY_W      = 4,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic reset_n,
  channel_model_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = WIDTH + 4;

  logic [1:0]              gain_sh;
  logic signed [WIDTH-1:0] echo_gain_sh;
  logic [DLY_W-1:0]        delay_sh;

  logic signed [WIDTH-1:0] dline [ECHO_DEPTH];
  logic [DLY_W-1:0]        wr_ptr;
  logic [DLY_W-1:0]        rd_ptr;
  logic signed [WIDTH-1:0] echo_x;
  logic signed [WIDTH-1:0] noise_c;

  logic signed [PW-1:0]    sig_ext;
  logic signed [PW-1:0]    echo_ext;
  logic signed [PW-1:0]    egain_ext;
  logic signed [PW-1:0]    p_main_c;
  logic signed [PW-1:0]    p_echo_c;

  logic signed [PW-1:0]    p_main_q;
  logic signed [PW-1:0]    p_echo_q;
  logic signed [WIDTH-1:0] noise_q;
  logic                    s1_vld;

  logic signed [PW-1:0]    main_shr;
  logic signed [PW-1:0]    echo_shr;
  logic signed [SW-1:0]    sum;
  logic                    ovf;
  logic signed [WIDTH-1:0] out_c;

  // Shadow registers feed the datapath, so a coincident sample still sees the old setting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain_sh      <= '0;
      echo_gain_sh <= '0;
      delay_sh     <= '0;
    end else if (bus.sym_clk_ena) begin
      gain_sh      <= bus.gain_set;
      echo_gain_sh <= bus.echo_gain;
      delay_sh     <= bus.echo_delay;
    end
  end

  // rd_ptr wraps modulo ECHO_DEPTH through the DLY_W-bit subtraction.
  always_comb begin
    rd_ptr    = wr_ptr - delay_sh;
    echo_x    = (bus.echo_en && (delay_sh != '0)) ? dline[rd_ptr] : '0;
    noise_c   = bus.awgn_en ? bus.noise_in : '0;
    sig_ext   = {{WIDTH{bus.sig_in[WIDTH-1]}}, bus.sig_in};
    echo_ext  = {{WIDTH{echo_x[WIDTH-1]}}, echo_x};
    egain_ext = {{WIDTH{echo_gain_sh[WIDTH-1]}}, echo_gain_sh};
    p_main_c  = sig_ext <<< (GAIN_FRAC + int'(gain_sh));
    p_echo_c  = echo_ext * egain_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ECHO_DEPTH; i++) dline[i] <= '0;
      wr_ptr   <= '0;
      p_main_q <= '0;
      p_echo_q <= '0;
      noise_q  <= '0;
      s1_vld   <= 1'b0;
    end else if (bus.sam_clk_ena) begin
      dline[wr_ptr] <= bus.sig_in;
      wr_ptr        <= wr_ptr + 1'b1;
      p_main_q      <= p_main_c;
      p_echo_q      <= p_echo_c;
      noise_q       <= noise_c;
      s1_vld        <= 1'b1;
    end
  end

  // Arithmetic shifts floor toward minus infinity; the sum carries 4 guard bits.
  always_comb begin
    main_shr = p_main_q >>> GAIN_FRAC;
    echo_shr = p_echo_q >>> GAIN_FRAC;
    sum      = main_shr[SW-1:0] + echo_shr[SW-1:0]
             + {{(SW-WIDTH){noise_q[WIDTH-1]}}, noise_q};
    ovf      = !((&sum[SW-1:WIDTH-1]) || !(|sum[SW-1:WIDTH-1]));
`ifdef CHAN_SAT_EN
    if (ovf) out_c = sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     out_c = sum[WIDTH-1:0];
`else
    out_c = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sig_out   <= '0;
      bus.sig_valid <= 1'b0;
    end else begin
      bus.sig_valid <= bus.sam_clk_ena && s1_vld;
      if (bus.sam_clk_ena) bus.sig_out <= out_c;
    end
  end

`ifdef CHAN_SAT_EN
  logic [CNT_W-1:0] sat_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_q <= '0;
    end else if (bus.sat_clr) begin
      sat_cnt_q <= '0;
    end else if (bus.sam_clk_ena && s1_vld && ovf && !(&sat_cnt_q)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign bus.sat_count = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat    = bus.sat_clr ^ ovf;
  assign bus.sat_count = '0;
`endif
endmodule

// File: tb/tb_channel_model_param.sv
// tb/tb_channel_model_param.sv - scoreboard bench for channel_model_param
module tb_channel_model_param;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   exp_q[$];

`ifdef CHAN_SAT_EN
  localparam int EP = 131071;
  localparam int EN = -131072;
  localparam int SAT = 1;
`else
  localparam int EP = 13568;
  localparam int EN = -13568;
  localparam int SAT = 0;
`endif

  channel_model_param_if #(.WIDTH(18), .DLY_W(4), .CNT_W(16)) bus ();

  channel_model_param #(
    .WIDTH(18), .GAIN_FRAC(9), .ECHO_DEPTH(16), .DLY_W(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.sig_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got sig_out %0d expected no output", int'(bus.sig_out));
      end else begin
        check("sig_out", int'(bus.sig_out), exp_q.pop_front());
      end
    end
  end

  task automatic send(input int s, input int e);
    bus.sig_in      = 18'(s);
    bus.sam_clk_ena = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.sam_clk_ena = 1'b0;
    bus.sym_clk_ena = 1'b0;
    bus.sat_clr     = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cfg(input int g, input int eg, input int ed);
    bus.gain_set    = 2'(g);
    bus.echo_gain   = 18'(eg);
    bus.echo_delay  = 4'(ed);
    bus.sym_clk_ena = 1'b1;
    @(posedge clk); #1;
    bus.sym_clk_ena = 1'b0;
  endtask

  initial begin
    int v0;
    reset_n         = 1'b0;
    bus.sam_clk_ena = 1'b0;
    bus.sym_clk_ena = 1'b0;
    bus.awgn_en     = 1'b0;
    bus.echo_en     = 1'b0;
    bus.gain_set    = '0;
    bus.echo_gain   = '0;
    bus.echo_delay  = '0;
    bus.noise_in    = '0;
    bus.sig_in      = '0;
    bus.sat_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sig_out", int'(bus.sig_out), 0);
    check("reset_sig_valid", int'(bus.sig_valid), 0);
    check("reset_sat_count", int'(bus.sat_count), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Gain step, including a sample coincident with the shadow load.
    send(1000, 1000);
    send(1000, 1000);
    bus.gain_set    = 2'd1;
    bus.sym_clk_ena = 1'b1;
    send(1000, 1000);
    send(1000, 2000);
    send(1000, 2000);

    // Noise on and off.
    cfg(0, 0, 0);
    bus.awgn_en  = 1'b1;
    bus.noise_in = -18'sd50;
    send(200, 150);
    bus.awgn_en  = 1'b0;
    send(200, 200);

    // Echo: clear recent history, then impulse.
    send(0, 0);
    send(0, 0);
    send(0, 0);
    cfg(0, 256, 3);
    bus.echo_en = 1'b1;
    send(4000, 4000);
    send(0, 0);
    send(0, 0);
    send(0, 2000);
    send(0, 0);
    cfg(0, 256, 0);
    send(4000, 4000);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    cfg(0, 256, 1);
    send(-3, -3);
    send(0, -2);
    bus.echo_en = 1'b0;

    // Saturation / wrap and the counter.
    cfg(3, 0, 0);
    send(100000, EP);
    send(-100000, EN);
    check("sat_count_1", int'(bus.sat_count), SAT);
    send(100000, EP);
    check("sat_count_2", int'(bus.sat_count), 2 * SAT);
    bus.sat_clr = 1'b1;
    send(0, 0);
    check("sat_count_clr", int'(bus.sat_count), 0);
    cfg(0, 0, 0);
    send(131071, 131071);
    send(-131072, -131072);
    send(0, 0);
    check("sat_count_edge", int'(bus.sat_count), 0);

    // Reset mid-stream with a loaded delay line.
    cfg(3, 0, 0);
    send(100000, EP);
    send(500, 4000);
    send(700, 5600);
    check("sat_count_pre_reset", int'(bus.sat_count), SAT);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_sig_out", int'(bus.sig_out), 0);
    check("async_reset_sat_count", int'(bus.sat_count), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cfg(0, 256, 3);
    bus.echo_en = 1'b1;
    v0 = valid_cnt;
    send(4000, 4000);
    check("no_valid_first_sample", valid_cnt, v0);
    send(0, 0);
    check("valid_second_sample", valid_cnt, v0 + 1);
    send(0, 0);
    send(0, 2000);
    send(0, 0);
    send(0, 0);
    check("pending_outputs", exp_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
